// File: rtl/screen_pkg.sv
// Shared screen encoding and default sizing for the tower game display path.
package screen_pkg;

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_PLAY    = 3'd1,
    S_PAUSE   = 3'd2,
    S_LVLDONE = 3'd3,
    S_OVER    = 3'd4,
    S_WIN     = 3'd5
  } screen_t;

  localparam int N_LEVELS_DEF    = 4;
  localparam int HOLD_FRAMES_DEF = 60;

  // Screens that start a fresh hold period when entered.
  function automatic logic is_hold_screen(input screen_t s);
    return (s == S_LVLDONE) || (s == S_OVER) || (s == S_WIN);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for level key inputs; press is combinational, one cycle wide.
// The first cycle after reset only captures the keys, so a key held through reset never reads as a press.
module edge_detect #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] press_o
);

  logic [W-1:0] key_q, key_d;
  logic         armed_q, armed_d;

  always_comb begin
    key_d   = d_i;
    armed_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      key_q   <= key_d;
      armed_q <= armed_d;
    end
  end

  assign press_o = armed_q ? (d_i & ~key_q) : '0;

endmodule

// File: rtl/screen_ctrl.sv
// Screen sequencer: keys and gameplay events queue one request, committed on the next frame_tick.
// Press-to-screen latency is at most one frame plus two cycles; all outputs are registered.
module screen_ctrl
  import screen_pkg::*;
#(
  parameter  int N_LEVELS    = N_LEVELS_DEF,
  parameter  int HOLD_FRAMES = HOLD_FRAMES_DEF,
  localparam int LVL_W       = $clog2(N_LEVELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             key_enter,
  input  logic             key_space,
  input  logic             key_esc,
  input  logic             player_dead,
  input  logic             level_done,
  output screen_t          screen_sel,
  output logic             game_run,
  output logic [LVL_W-1:0] level_idx,
  output logic             level_load
);

  localparam int               HOLD_W   = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);
  localparam logic [LVL_W-1:0]  LVL_LAST = LVL_W'(N_LEVELS - 1);

  logic [2:0] press;
  logic       confirm, esc_press;

  edge_detect #(.W(3)) u_keys (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     ({key_esc, key_space, key_enter}),
    .press_o (press)
  );

  assign confirm   = press[0] | press[1];
  assign esc_press = press[2];

  screen_t           state_q, state_d, pend_state_q, pend_state_d, req_state;
  logic              pend_vld_q, pend_vld_d, req_vld;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic              run_q, run_d, load_q, load_d;
  logic              hold_exp, commit;

  assign hold_exp = (hold_q == HOLD_MAX);
  assign commit   = frame_tick & pend_vld_q;

  always_comb begin
    req_vld   = 1'b0;
    req_state = state_q;
    case (state_q)
      S_START: if (confirm) begin
        req_vld   = 1'b1;
        req_state = S_PLAY;
      end
      S_PLAY: begin
        // Death outranks level completion when both arrive together.
        if (player_dead) begin
          req_vld   = 1'b1;
          req_state = S_OVER;
        end else if (level_done) begin
          req_vld   = 1'b1;
          req_state = S_LVLDONE;
        end else if (esc_press) begin
          req_vld   = 1'b1;
          req_state = S_PAUSE;
        end
      end
      S_PAUSE: if (esc_press || confirm) begin
        req_vld   = 1'b1;
        req_state = S_PLAY;
      end
      S_LVLDONE: if (hold_exp) begin
        req_vld   = 1'b1;
        req_state = (lvl_q == LVL_LAST) ? S_WIN : S_PLAY;
      end
      S_OVER, S_WIN: if (hold_exp && confirm) begin
        req_vld   = 1'b1;
        req_state = S_START;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pend_vld_d   = pend_vld_q;
    pend_state_d = pend_state_q;
    hold_d       = hold_q;
    lvl_d        = lvl_q;
    run_d        = run_q;
    load_d       = 1'b0;
    if (frame_tick && !hold_exp) hold_d = hold_q + HOLD_W'(1);
    if (commit) begin
      pend_vld_d = 1'b0;
      state_d    = pend_state_q;
      run_d      = (pend_state_q == S_PLAY);
      // The entry tick itself must not count toward the hold.
      if (is_hold_screen(pend_state_q)) hold_d = '0;
      if (pend_state_q == S_PLAY && state_q == S_START) begin
        lvl_d  = '0;
        load_d = 1'b1;
      end else if (pend_state_q == S_PLAY && state_q == S_LVLDONE) begin
        lvl_d  = lvl_q + LVL_W'(1);
        load_d = 1'b1;
      end
    end else if (!pend_vld_q && req_vld) begin
      pend_vld_d   = 1'b1;
      pend_state_d = req_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_START;
      pend_vld_q   <= 1'b0;
      pend_state_q <= S_START;
      hold_q       <= '0;
      lvl_q        <= '0;
      run_q        <= 1'b0;
      load_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_vld_q   <= pend_vld_d;
      pend_state_q <= pend_state_d;
      hold_q       <= hold_d;
      lvl_q        <= lvl_d;
      run_q        <= run_d;
      load_q       <= load_d;
    end
  end

  assign screen_sel = state_q;
  assign game_run   = run_q;
  assign level_idx  = lvl_q;
  assign level_load = load_q;

endmodule

// File: tb/tb_screen_ctrl.sv
// Scoreboard bench for screen_ctrl: stimulus queues expected screen events, a monitor checks them.
module tb_screen_ctrl;
  import screen_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [2:0] keys = 3'b000;
  logic       player_dead = 1'b0;
  logic       level_done = 1'b0;
  screen_t    screen_sel;
  logic       game_run;
  logic [1:0] level_idx;
  logic       level_load;

  localparam int KEY_ENTER = 0;
  localparam int KEY_SPACE = 1;
  localparam int KEY_ESC   = 2;

  screen_ctrl #(.N_LEVELS(4), .HOLD_FRAMES(60)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .key_enter   (keys[KEY_ENTER]),
    .key_space   (keys[KEY_SPACE]),
    .key_esc     (keys[KEY_ESC]),
    .player_dead (player_dead),
    .level_done  (level_done),
    .screen_sel  (screen_sel),
    .game_run    (game_run),
    .level_idx   (level_idx),
    .level_load  (level_load)
  );

  always #5 clk = ~clk;

  typedef struct {
    screen_t    sel;
    logic       run;
    logic [1:0] idx;
    logic       load;
  } exp_t;

  exp_t    exp_q[$];
  exp_t    mon_e;
  screen_t prev_sel = S_START;
  int      total = 0;
  int      bad = 0;

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input screen_t s, input logic r, input logic [1:0] i, input logic l);
    exp_t e;
    e.sel = s; e.run = r; e.idx = i; e.load = l;
    return e;
  endfunction

  // A screen change or a load strobe is one observable event.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sel = screen_sel;
    end else begin
      if (screen_sel != prev_sel || level_load) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event_sel", int'(screen_sel), int'(prev_sel));
          check("unexpected_event_load", int'(level_load), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("ev_screen_sel", int'(screen_sel), int'(mon_e.sel));
          check("ev_game_run", int'(game_run), int'(mon_e.run));
          check("ev_level_idx", int'(level_idx), int'(mon_e.idx));
          check("ev_level_load", int'(level_load), int'(mon_e.load));
        end
      end
      prev_sel = screen_sel;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(3);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input int k);
    keys[k] = 1'b1;
    cyc(1);
    keys[k] = 1'b0;
    cyc(1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_screen_sel"}, int'(screen_sel), int'(S_START));
    check({tag, "_game_run"}, int'(game_run), 0);
    check({tag, "_level_idx"}, int'(level_idx), 0);
    check({tag, "_level_load"}, int'(level_load), 0);
  endtask

  initial begin
    cyc(3);
    check_reset("reset");
    rst_n = 1'b1;
    cyc(2);

    // Start: enter pulse, tick five cycles later.
    keys[KEY_ENTER] = 1'b1;
    cyc(1);
    keys[KEY_ENTER] = 1'b0;
    cyc(4);
    exp_q.push_back(mk(S_PLAY, 1'b1, 2'd0, 1'b1));
    tick();

    // Death and level completion together: death wins.
    player_dead = 1'b1;
    level_done  = 1'b1;
    cyc(1);
    player_dead = 1'b0;
    level_done  = 1'b0;
    cyc(2);
    exp_q.push_back(mk(S_OVER, 1'b0, 2'd0, 1'b0));
    tick();

    // Game over hold: early confirms ignored, confirm after expiry accepted.
    ticks(10);
    press(KEY_ENTER);
    ticks(39);
    press(KEY_ENTER);
    ticks(10);
    check("over_hold_stays", int'(screen_sel), int'(S_OVER));
    press(KEY_ENTER);
    ticks(1);
    check("over_hold_59_ignored", int'(screen_sel), int'(S_OVER));
    press(KEY_ENTER);
    exp_q.push_back(mk(S_START, 1'b0, 2'd0, 1'b0));
    tick();

    // A frame_tick in the press cycle must not commit that request.
    keys[KEY_ENTER] = 1'b1;
    frame_tick      = 1'b1;
    cyc(1);
    keys[KEY_ENTER] = 1'b0;
    frame_tick      = 1'b0;
    cyc(3);
    check("same_cycle_tick_no_commit", int'(screen_sel), int'(S_START));
    exp_q.push_back(mk(S_PLAY, 1'b1, 2'd0, 1'b1));
    tick();

    // Pause ignores gameplay events; resume does not reload.
    press(KEY_ESC);
    exp_q.push_back(mk(S_PAUSE, 1'b0, 2'd0, 1'b0));
    tick();
    level_done  = 1'b1;
    player_dead = 1'b1;
    ticks(2);
    check("pause_ignores_events", int'(screen_sel), int'(S_PAUSE));
    level_done  = 1'b0;
    player_dead = 1'b0;
    cyc(1);
    press(KEY_ENTER);
    exp_q.push_back(mk(S_PLAY, 1'b1, 2'd0, 1'b0));
    tick();

    // Walk the tower: three level advances, then the win screen.
    for (int lvl = 0; lvl < 4; lvl++) begin
      level_done = 1'b1;
      cyc(1);
      level_done = 1'b0;
      cyc(1);
      exp_q.push_back(mk(S_LVLDONE, 1'b0, 2'(lvl), 1'b0));
      tick();
      ticks(60);
      check("lvldone_held", int'(screen_sel), int'(S_LVLDONE));
      if (lvl < 3) exp_q.push_back(mk(S_PLAY, 1'b1, 2'(lvl + 1), 1'b1));
      else         exp_q.push_back(mk(S_WIN, 1'b0, 2'd3, 1'b0));
      tick();
    end

    // Win screen: early space ignored, later space returns to start.
    ticks(5);
    press(KEY_SPACE);
    ticks(55);
    check("win_held", int'(screen_sel), int'(S_WIN));
    press(KEY_SPACE);
    exp_q.push_back(mk(S_START, 1'b0, 2'd3, 1'b0));
    tick();

    // Reset with a request pending and space held through release.
    press(KEY_ENTER);
    keys[KEY_SPACE] = 1'b1;
    rst_n = 1'b0;
    cyc(3);
    check_reset("midreset");
    rst_n = 1'b1;
    cyc(3);
    ticks(2);
    check("held_space_no_press", int'(screen_sel), int'(S_START));
    keys[KEY_SPACE] = 1'b0;
    cyc(2);
    press(KEY_ENTER);
    exp_q.push_back(mk(S_PLAY, 1'b1, 2'd0, 1'b1));
    tick();

    cyc(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
